// File: rtl/fp_div_sequencer_pkg.sv
// Shared widths, bit indices and state encoding for the fp_div issue/collect sequencer.
// Flag layout mirrors ieee-754-flags.vh so values pass straight through to and from fp_div.
package fp_div_sequencer_pkg;

    localparam int unsigned NRAS        = 4;
    localparam int unsigned NTYPES      = 6;
    localparam int unsigned NEXCEPTIONS = 5;

    // rounding attribute bit indices (one-hot, NRAS+1 bits)
    localparam int unsigned ROUND_TIES_TO_EVEN    = 0;
    localparam int unsigned ROUND_TOWARD_ZERO     = 1;
    localparam int unsigned ROUND_TOWARD_POSITIVE = 2;
    localparam int unsigned ROUND_TOWARD_NEGATIVE = 3;
    localparam int unsigned ROUND_TIES_TO_AWAY    = 4;

    // result type bit indices
    localparam int unsigned TYPE_NORMAL    = 0;
    localparam int unsigned TYPE_SUBNORMAL = 1;
    localparam int unsigned TYPE_ZERO      = 2;
    localparam int unsigned TYPE_INFINITY  = 3;
    localparam int unsigned TYPE_QNAN      = 4;
    localparam int unsigned TYPE_SNAN      = 5;

    // exception bit indices
    localparam int unsigned EXC_INEXACT        = 0;
    localparam int unsigned EXC_UNDERFLOW      = 1;
    localparam int unsigned EXC_OVERFLOW       = 2;
    localparam int unsigned EXC_DIVIDE_BY_ZERO = 3;
    localparam int unsigned EXC_INVALID        = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT0 = 2'd2,
        S_WAIT  = 2'd3
    } seq_state_t;

    // width of one buffered {a, b, ra} request
    function automatic int unsigned req_width(input int unsigned nexp, input int unsigned nsig);
        return 2 * (nexp + nsig + 1) + NRAS + 1;
    endfunction

endpackage

// File: rtl/fp_div_sequencer_if.sv
// Request and result handshakes of the sequencer; master drives requests, slave is the sequencer.
interface fp_div_sequencer_if
    import fp_div_sequencer_pkg::*;
#(
    parameter int unsigned NEXP = 5,
    parameter int unsigned NSIG = 10
);
    localparam int unsigned NW = NEXP + NSIG + 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [NW-1:0]          in_a;
    logic [NW-1:0]          in_b;
    logic [NRAS:0]          in_ra;
    logic                   out_valid;
    logic                   out_ready;
    logic [NW-1:0]          out_q;
    logic [NTYPES-1:0]      out_flags;
    logic [NEXCEPTIONS-1:0] out_exc;

    modport master (
        output in_valid, in_a, in_b, in_ra, out_ready,
        input  in_ready, out_valid, out_q, out_flags, out_exc
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ra, out_ready,
        output in_ready, out_valid, out_q, out_flags, out_exc
    );

endinterface

// File: rtl/fp_div_sequencer_fifo.sv
// Count-based synchronous request FIFO; a push is refused while full even if a pop coincides.
module fp_op_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // storage needs no reset; count gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fp_div_sequencer.sv
// Issues buffered divide requests to fp_div one at a time, collects results onto a
// valid/ready output and keeps sticky exception and timeout status.
module fp_div_sequencer
    import fp_div_sequencer_pkg::*;
#(
    parameter int unsigned NEXP  = 5,
    parameter int unsigned NSIG  = 10,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TMO   = NSIG + 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fp_div_sequencer_if.slave      bus,
    output logic                   div_start,
    output logic [NEXP+NSIG:0]     div_a,
    output logic [NEXP+NSIG:0]     div_b,
    output logic [NRAS:0]          div_ra,
    input  logic [NEXP+NSIG:0]     div_q,
    input  logic [NTYPES-1:0]      div_flags,
    input  logic [NEXCEPTIONS-1:0] div_exc,
    input  logic                   div_done,
    input  logic                   clear_status,
    output logic [NEXCEPTIONS-1:0] status,
    output logic                   timeout,
    output logic                   busy
);
    localparam int unsigned NW = NEXP + NSIG + 1;
    localparam int unsigned RW = req_width(NEXP, NSIG);
    localparam int unsigned TW = $clog2(TMO + 1);

    localparam logic [NW-1:0]          QNAN_Q      = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
    localparam logic [NTYPES-1:0]      QNAN_FLAGS  = NTYPES'(1) << TYPE_QNAN;
    localparam logic [NEXCEPTIONS-1:0] INVALID_EXC = NEXCEPTIONS'(1) << EXC_INVALID;

    seq_state_t             state;
    logic [TW-1:0]          wait_cnt;
    logic [RW-1:0]          fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   capture;
    logic                   timed_out;
    logic [NEXCEPTIONS-1:0] cap_exc;

    fp_op_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (capture),
        .din   ({bus.in_a, bus.in_b, bus.in_ra}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.in_ready = !rst && !fifo_full;
    assign fifo_push    = bus.in_valid && bus.in_ready;

    // a real done always beats a timeout landing in the same cycle
    assign capture   = (state == S_WAIT) && (div_done || (wait_cnt == TW'(TMO)));
    assign timed_out = (state == S_WAIT) && !div_done && (wait_cnt == TW'(TMO));
    assign cap_exc   = !capture ? '0 : (timed_out ? INVALID_EXC : div_exc);

    assign busy = (state != S_IDLE) || !fifo_empty || bus.out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            div_start     <= 1'b0;
            div_a         <= '0;
            div_b         <= '0;
            div_ra        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_q     <= '0;
            bus.out_flags <= '0;
            bus.out_exc   <= '0;
            status        <= '0;
            timeout       <= 1'b0;
        end else begin
            div_start <= 1'b0;
            if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

            case (state)
                // out_valid here is the pre-consume value, so a consume never issues in the same cycle
                S_IDLE: begin
                    if (!fifo_empty && !bus.out_valid) begin
                        {div_a, div_b, div_ra} <= fifo_head;
                        div_start              <= 1'b1;
                        state                  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= TW'(1);
                    state    <= S_WAIT0;
                end
                S_WAIT0: begin
                    wait_cnt <= wait_cnt + TW'(1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (capture) begin
                        bus.out_valid <= 1'b1;
                        bus.out_q     <= timed_out ? QNAN_Q     : div_q;
                        bus.out_flags <= timed_out ? QNAN_FLAGS : div_flags;
                        bus.out_exc   <= cap_exc;
                        state         <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            status  <= (clear_status ? '0 : status) | cap_exc;
            timeout <= (clear_status ? 1'b0 : timeout) | timed_out;
        end
    end

endmodule
